// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : matmul_pkg
//  Purpose  : Shared types and packing helpers for the matrix-multiply
//             datapath (array_regenerate / array_collect).
//  Revision : 1.0 - initial release
// ============================================================================
package matmul_pkg;

   // Collector control states.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      HOLD    = 2'd2
   } state_t;

   // LSB position of array column j inside a Y_COL-wide bus, column 0 in the MSBs.
   function automatic int col_lsb(input int j, input int y_col, input int width);
      return (y_col - 1 - j) * width;
   endfunction

   // LSB position of element (i,j) inside a row-major, MSB-first packed matrix.
   function automatic int mat_lsb(input int i, input int j, input int x_row,
                                  input int y_col, input int width);
      return (x_row * y_col - 1 - (i * y_col + j)) * width;
   endfunction

endpackage
`default_nettype wire

// File: rtl/array_collect.sv
`default_nettype none
// ============================================================================
//  Module   : array_collect
//  Purpose  : Reassembles the diagonally skewed result stream draining out of
//             the systolic array into a packed X_ROW x Y_COL matrix and offers
//             it downstream through a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module array_collect
   import matmul_pkg::*;
#(
   parameter int OUT_WIDTH = 16,
   parameter int X_ROW     = 3,
   parameter int Y_COL     = 3
) (
   input  logic                               sys_clk,
   input  logic                               sys_rst,
   input  logic                               start,
   input  logic [Y_COL*OUT_WIDTH-1:0]         in_data,
   input  logic                               z_ready,
   output logic [X_ROW*Y_COL*OUT_WIDTH-1:0]   Z,
   output logic                               z_valid,
   output logic                               busy,
   output logic                               err_overrun
);

   // Stream length and width of the stream-cycle counter.
   localparam int             c_LEN    = X_ROW + Y_COL - 1;
   localparam int             c_KW     = $clog2(c_LEN + 1);
   localparam logic [c_KW-1:0] c_K_LAST = c_KW'(c_LEN - 1);
   localparam logic [c_KW-1:0] c_K_ONE  = c_KW'(1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [c_KW-1:0]   r_k;
   logic [c_KW-1:0]   w_k_nxt;
   logic              r_err;
   logic              w_err_nxt;
   logic              w_launch;
   logic              w_cap_en;
   logic [c_KW-1:0]   w_cap_k;

   // A new collection may begin from IDLE, or from HOLD on the very edge the
   // current matrix is accepted (zero-bubble back-to-back operation).
   assign w_launch = start && ((r_state == IDLE) || ((r_state == HOLD) && z_ready));

   // Next-state, counter and capture-phase decode.
   always_comb begin
      w_state_nxt = r_state;
      w_k_nxt     = r_k;
      w_err_nxt   = 1'b0;
      w_cap_en    = 1'b0;
      w_cap_k     = '0;
      if (w_launch) begin
         // Stream cycle k=0 is live on in_data right now.
         w_cap_en = 1'b1;
         w_cap_k  = '0;
         if (c_LEN == 1) begin
            w_state_nxt = HOLD;
            w_k_nxt     = '0;
         end else begin
            w_state_nxt = COLLECT;
            w_k_nxt     = c_K_ONE;
         end
      end else begin
         case (r_state)
            IDLE: begin
               w_state_nxt = IDLE;
            end
            COLLECT: begin
               w_cap_en  = 1'b1;
               w_cap_k   = r_k;
               w_err_nxt = start;
               if (r_k == c_K_LAST) begin
                  w_state_nxt = HOLD;
                  w_k_nxt     = '0;
               end else begin
                  w_k_nxt = r_k + c_K_ONE;
               end
            end
            HOLD: begin
               // Accept without a new start falls back to IDLE; a start that
               // cannot be honoured because Z is still pending is dropped.
               if (z_ready) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_err_nxt = start;
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_k_nxt     = '0;
            end
         endcase
      end
   end

   // Control state, stream counter and overrun pulse registers.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state <= IDLE;
         r_k     <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_k     <= w_k_nxt;
         r_err   <= w_err_nxt;
      end
   end

   // One register per result element; element (i,j) is on column j exactly
   // when the stream counter equals i+j, so equality alone bounds the window.
   for (genvar gi = 0; gi < X_ROW; gi++) begin : g_row
      for (genvar gj = 0; gj < Y_COL; gj++) begin : g_col
         localparam logic [c_KW-1:0] c_IDX = c_KW'(gi + gj);
         localparam int c_ZL = mat_lsb(gi, gj, X_ROW, Y_COL, OUT_WIDTH);
         localparam int c_DL = col_lsb(gj, Y_COL, OUT_WIDTH);

         logic [OUT_WIDTH-1:0] r_elem;

         // Copy the element bit-exact when its diagonal passes by.
         always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
               r_elem <= '0;
            end else if (w_cap_en && (w_cap_k == c_IDX)) begin
               r_elem <= in_data[c_DL +: OUT_WIDTH];
            end
         end

         assign Z[c_ZL +: OUT_WIDTH] = r_elem;
      end
   end

   assign z_valid     = (r_state == HOLD);
   assign busy        = (r_state == COLLECT);
   assign err_overrun = r_err;

endmodule
`default_nettype wire

// File: tb/tb_array_collect.sv
`default_nettype none
// ============================================================================
//  Module   : tb_array_collect
//  Purpose  : Self-checking bench for array_collect (3x3, 3x1 and 1x1 builds)
//             against a matrix-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_array_collect;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // 3x3 instance
   logic          s33, r33;
   logic [47:0]   d33;
   logic [143:0]  z33;
   logic          v33, b33, e33;
   // 3x1 instance
   logic          s31, r31;
   logic [15:0]   d31;
   logic [47:0]   z31;
   logic          v31, b31, e31;
   // 1x1 instance
   logic          s11, r11;
   logic [15:0]   d11;
   logic [15:0]   z11;
   logic          v11, b11, e11;

   array_collect #(.OUT_WIDTH(16), .X_ROW(3), .Y_COL(3)) u_33 (
      .sys_clk(clk), .sys_rst(rst), .start(s33), .in_data(d33), .z_ready(r33),
      .Z(z33), .z_valid(v33), .busy(b33), .err_overrun(e33));

   array_collect #(.OUT_WIDTH(16), .X_ROW(3), .Y_COL(1)) u_31 (
      .sys_clk(clk), .sys_rst(rst), .start(s31), .in_data(d31), .z_ready(r31),
      .Z(z31), .z_valid(v31), .busy(b31), .err_overrun(e31));

   array_collect #(.OUT_WIDTH(16), .X_ROW(1), .Y_COL(1)) u_11 (
      .sys_clk(clk), .sys_rst(rst), .start(s11), .in_data(d11), .z_ready(r11),
      .Z(z11), .z_valid(v11), .busy(b11), .err_overrun(e11));

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference matrix for the 3x3 build.
   logic [15:0] m33 [3][3];
   logic [15:0] m31 [3];

   function automatic logic [143:0] pack33();
      logic [143:0] p;
      p = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            p[(8 - (i*3 + j))*16 +: 16] = m33[i][j];
      return p;
   endfunction

   // Bus contents at stream cycle k: element (k-j, j) inside its window, junk outside.
   function automatic logic [47:0] col33(input int k);
      logic [47:0] d;
      for (int j = 0; j < 3; j++) begin
         if (k >= j && (k - j) < 3) d[(2-j)*16 +: 16] = m33[k-j][j];
         else                       d[(2-j)*16 +: 16] = 16'($urandom);
      end
      return d;
   endfunction

   task automatic rand33();
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            m33[i][j] = 16'($urandom);
   endtask

   task automatic spec33();
      m33[0][0] = 16'h002A; m33[0][1] = 16'h0024; m33[0][2] = 16'h001E;
      m33[1][0] = 16'h0060; m33[1][1] = 16'h0051; m33[1][2] = 16'h0042;
      m33[2][0] = 16'h0096; m33[2][1] = 16'h007E; m33[2][2] = 16'h0066;
   endtask

   // Stream one 3x3 matrix. ready_first drives z_ready on the start cycle
   // (accept+start), overrun_k injects a stray start at that stream cycle,
   // abort_k asserts reset asynchronously while the counter sits at that value.
   task automatic run33(input bit ready_first, input int overrun_k, input int abort_k);
      logic [143:0] exp;
      exp = pack33();
      s33 = 1'b1; r33 = ready_first; d33 = col33(0);
      for (int k = 1; k <= 4; k++) begin
         cyc();
         chk("busy33", b33, 1'b1);
         chk("nvalid33", v33, 1'b0);
         chk("err33", e33, (overrun_k >= 0 && k == overrun_k + 1));
         s33 = (k == overrun_k); r33 = 1'b0; d33 = col33(k);
         if (k == abort_k) begin
            #1 rst = 1'b1;
            #1;
            chk("rst_z33", z33, '0);
            chk("rst_busy33", b33, 1'b0);
            chk("rst_valid33", v33, 1'b0);
            s33 = 1'b0;
            cyc();
            rst = 1'b0;
            cyc();
            chk("post_rst_valid33", v33, 1'b0);
            return;
         end
      end
      cyc();
      chk("valid33", v33, 1'b1);
      chk("busy33_done", b33, 1'b0);
      chk("z33", z33, exp);
      s33 = 1'b0; d33 = 48'hFFFF_FFFF_FFFF;
   endtask

   task automatic hold33(input int n, input logic [143:0] exp);
      for (int c = 0; c < n; c++) begin
         r33 = 1'b0;
         cyc();
         chk("hold_valid33", v33, 1'b1);
         chk("hold_z33", z33, exp);
      end
   endtask

   task automatic accept33();
      r33 = 1'b1;
      cyc();
      chk("accepted33", v33, 1'b0);
      r33 = 1'b0;
   endtask

   localparam logic [143:0] c_SPEC_Z =
      144'h002A_0024_001E_0060_0051_0042_0096_007E_0066;

   initial begin
      logic [143:0] prev;
      logic [15:0]  v;

      rst = 1'b1;
      s33 = 0; r33 = 0; d33 = '1;
      s31 = 0; r31 = 0; d31 = '1;
      s11 = 0; r11 = 0; d11 = '1;
      cyc(); cyc();
      chk("reset_z33", z33, '0);
      chk("reset_v33", v33, 1'b0);
      chk("reset_b33", b33, 1'b0);
      chk("reset_e33", e33, 1'b0);
      chk("reset_z31", z31, '0);
      chk("reset_z11", z11, '0);
      rst = 1'b0;
      cyc();

      // Known 3x3 stream, then hold for 4 cycles, then accept+start of all-ones.
      spec33();
      run33(1'b0, -1, -1);
      chk("spec_z33", z33, c_SPEC_Z);
      hold33(4, c_SPEC_Z);
      for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) m33[i][j] = 16'h0001;
      run33(1'b1, -1, -1);
      accept33();

      // Stray start during COLLECT at k=2 must be ignored.
      spec33();
      run33(1'b0, 2, -1);
      chk("overrun_z33", z33, c_SPEC_Z);
      // Start in HOLD while downstream is stalled is dropped.
      s33 = 1'b1; r33 = 1'b0;
      cyc();
      s33 = 1'b0;
      chk("hold_err33", e33, 1'b1);
      chk("hold_err_valid33", v33, 1'b1);
      cyc();
      chk("hold_err_clear33", e33, 1'b0);
      chk("hold_err_busy33", b33, 1'b0);
      chk("hold_err_z33", z33, c_SPEC_Z);
      accept33();

      // Asynchronous reset mid-collection, then a fresh collection.
      rand33();
      run33(1'b0, -1, 3);
      rand33();
      run33(1'b0, -1, -1);
      accept33();

      // Randomized back-to-back traffic with random downstream stalls.
      rand33();
      run33(1'b0, -1, -1);
      for (int it = 0; it < 8; it++) begin
         prev = pack33();
         hold33($urandom_range(0, 3), prev);
         rand33();
         if ($urandom_range(0, 1) == 1) begin
            run33(1'b1, -1, -1);
         end else begin
            accept33();
            for (int g = $urandom_range(0, 2); g > 0; g--) cyc();
            run33(1'b0, -1, -1);
         end
      end
      accept33();

      // 3x1: known stream, then two random ones; column has no out-of-window slot.
      m31[0] = 16'h000E; m31[1] = 16'h0020; m31[2] = 16'h0032;
      for (int it = 0; it < 3; it++) begin
         if (it > 0) for (int i = 0; i < 3; i++) m31[i] = 16'($urandom);
         s31 = 1'b1; d31 = m31[0];
         for (int k = 1; k <= 2; k++) begin
            cyc();
            s31 = 1'b0;
            chk("busy31", b31, 1'b1);
            chk("nvalid31", v31, 1'b0);
            d31 = m31[k];
         end
         cyc();
         d31 = 16'hFFFF;
         chk("valid31", v31, 1'b1);
         chk("z31", z31, {m31[0], m31[1], m31[2]});
         cyc();
         chk("hold_z31", z31, {m31[0], m31[1], m31[2]});
         r31 = 1'b1;
         cyc();
         r31 = 1'b0;
         chk("accepted31", v31, 1'b0);
      end

      // 1x1: single-cycle stream, busy never asserted.
      s11 = 1'b1; d11 = 16'h1234;
      cyc();
      s11 = 1'b0; d11 = 16'hFFFF;
      chk("valid11", v11, 1'b1);
      chk("busy11", b11, 1'b0);
      chk("z11", z11, 16'h1234);
      for (int it = 0; it < 4; it++) begin
         v = 16'($urandom);
         s11 = 1'b1; r11 = 1'b1; d11 = v;
         cyc();
         s11 = 1'b0; r11 = 1'b0; d11 = 16'hFFFF;
         chk("b2b_valid11", v11, 1'b1);
         chk("b2b_busy11", b11, 1'b0);
         chk("b2b_z11", z11, v);
      end
      r11 = 1'b1;
      cyc();
      r11 = 1'b0;
      chk("accepted11", v11, 1'b0);
      chk("kept_z11", z11, v);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global guard so the run cannot hang.
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
